// File: rtl/kyber_pkg.sv
// Shared Kyber constants, compression FSM state type and depth legality check.
package kyber_pkg;

  localparam int unsigned KYBER_Q = 3329;
  localparam int unsigned KYBER_N = 256;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned IDX_W   = 8;
  localparam int unsigned D_W     = 4;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} cmp_state_t;

  // Compression depths used by the ciphertext packer: 1 (message), 4/5 (v), 10/11 (u).
  function automatic logic d_legal(input logic [3:0] d);
    case (d)
      4'd1, 4'd4, 4'd5, 4'd10, 4'd11: d_legal = 1'b1;
      default:                        d_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/compress_seq_if.sv
// Coefficient input stream and compressed output stream of compress_seq.
interface compress_seq_if;
  import kyber_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_coeff;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;

  modport master (
    output in_valid, in_coeff, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_coeff, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );

endinterface

// File: rtl/compress_module.sv
// Combinational Kyber compression: result = ((x << d) + Q/2) / Q, masked to d bits.
module compress_module
  import kyber_pkg::*;
(
  input  logic [15:0] x,
  input  logic [15:0] d,
  output logic [15:0] result
);

  logic [31:0] scaled;
  logic [31:0] quot;
  logic [31:0] mask;

  // Scale, round to nearest, then keep the low d bits.
  always_comb begin
    scaled = (32'(x) << d) + 32'(KYBER_Q / 2);
    quot   = scaled / 32'(KYBER_Q);
    mask   = (32'd1 << d) - 32'd1;
    result = 16'(quot & mask);
  end

endmodule

// File: rtl/compress_seq.sv
// Streams one 256-coefficient polynomial through compress_module with a registered output stage.
module compress_seq
  import kyber_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [D_W-1:0] d_sel,
  compress_seq_if.slave  bus,
  output logic           busy,
  output logic           done,
  output logic           d_err,
  output logic           range_err
);

  cmp_state_t        state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [D_W-1:0]    d_reg_q, d_reg_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic              out_last_q, out_last_d;
  logic              d_err_q, d_err_d;
  logic              range_err_q, range_err_d;

  logic              in_ready_c;
  logic              push_c;
  logic              pop_c;
  logic              coeff_oor_c;
  logic [DATA_W-1:0] cmp_result;

  compress_module u_compress (
    .x      (bus.in_coeff),
    .d      (16'(d_reg_q)),
    .result (cmp_result)
  );

  // Handshake qualifiers for the single-entry output stage.
  always_comb begin
    in_ready_c  = (state_q == RUN) && (!out_valid_q || bus.out_ready);
    push_c      = in_ready_c && bus.in_valid;
    pop_c       = out_valid_q && bus.out_ready;
    coeff_oor_c = bus.in_coeff >= DATA_W'(KYBER_Q);
  end

  // Next-state, counter and output-stage update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    d_reg_d     = d_reg_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    d_err_d     = 1'b0;
    range_err_d = range_err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (d_legal(d_sel)) begin
            d_reg_d     = d_sel;
            cnt_d       = '0;
            range_err_d = 1'b0;
            state_d     = RUN;
          end else begin
            d_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (push_c) begin
          out_data_d  = coeff_oor_c ? '0 : cmp_result;
          out_idx_d   = cnt_q;
          out_last_d  = (cnt_q == IDX_W'(KYBER_N - 1));
          out_valid_d = 1'b1;
          cnt_d       = cnt_q + IDX_W'(1);
          if (coeff_oor_c) range_err_d = 1'b1;
          if (cnt_q == IDX_W'(KYBER_N - 1)) state_d = DRAIN;
        end else if (pop_c) begin
          out_valid_d = 1'b0;
        end
      end
      DRAIN: begin
        if (pop_c) begin
          out_valid_d = 1'b0;
          if (out_last_q) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything; the range flag survives it.
    if (abort) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      cnt_d       = '0;
      d_err_d     = 1'b0;
      range_err_d = range_err_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      d_reg_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      d_err_q     <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      d_reg_q     <= d_reg_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      d_err_q     <= d_err_d;
      range_err_q <= range_err_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
  assign busy          = (state_q == RUN) || (state_q == DRAIN);
  assign done          = (state_q == DONE);
  assign d_err         = d_err_q;
  assign range_err     = range_err_q;

endmodule

// File: tb/tb_compress_seq.sv
// Self-checking bench for compress_seq: randomized streams against a queue-based model.
module tb_compress_seq;
  import kyber_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] d_sel;
  logic       busy, done, d_err, range_err;

  compress_seq_if bus ();

  compress_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .d_sel     (d_sel),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .d_err     (d_err),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Round-half-up of x*2^d/q, reduced mod 2^d; out-of-range inputs give 0.
  function automatic int m_compress(input int x, input int d);
    int p;
    if (x >= 3329) return 0;
    p = 1 << d;
    return ((2 * x * p + 3329) / (2 * 3329)) % p;
  endfunction

  function automatic bit m_legal(input int d);
    return (d == 1) || (d == 4) || (d == 5) || (d == 10) || (d == 11);
  endfunction

  typedef struct {
    int data;
    int idx;
    bit last;
  } exp_t;

  exp_t q[$];
  bit   m_busy, m_done, m_derr, m_rerr;
  int   m_acc, m_d;
  int   cyc, done_cnt, cyc_done, cyc_last, pop_cnt, last_cnt, first_idx;
  int   dut_log[256];
  int   coeffs[256];
  int   rr_mode = 0;

  // Out_ready pattern: 0 always ready, 1 random, 2 stalled.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        2:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Reference model + per-cycle compare at the falling edge.
  initial begin
    bit   exp_ir, push, pop, new_done, new_derr;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        q.delete();
        m_busy = 0; m_done = 0; m_derr = 0; m_rerr = 0; m_acc = 0; m_d = 0;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_range_err", int'(range_err), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        continue;
      end
      exp_ir = m_busy && (m_acc < 256) && (q.size() == 0 || bus.out_ready);
      chk("in_ready", int'(bus.in_ready), int'(exp_ir));
      chk("out_valid", int'(bus.out_valid), int'(q.size() != 0));
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_done));
      chk("d_err", int'(d_err), int'(m_derr));
      chk("range_err", int'(range_err), int'(m_rerr));
      if (bus.out_valid && q.size() != 0) begin
        chk("out_data", int'(bus.out_data), q[0].data);
        chk("out_idx", int'(bus.out_idx), q[0].idx);
        chk("out_last", int'(bus.out_last), int'(q[0].last));
      end
      if (done) begin
        done_cnt++;
        cyc_done = cyc;
      end
      if (bus.out_valid && bus.out_ready) begin
        dut_log[bus.out_idx] = int'(bus.out_data);
        if (pop_cnt == 0) first_idx = int'(bus.out_idx);
        pop_cnt++;
        if (bus.out_last) begin
          last_cnt++;
          cyc_last = cyc;
        end
      end
      // Advance the model with the inputs that the next rising edge will see.
      pop      = (q.size() != 0) && bus.out_ready;
      push     = exp_ir && bus.in_valid;
      new_done = 0;
      new_derr = 0;
      if (abort) begin
        q.delete();
        m_busy = 0;
        m_acc  = 0;
      end else begin
        if (pop) begin
          e = q.pop_front();
          if (e.last) begin
            m_busy   = 0;
            new_done = 1;
          end
        end
        if (push) begin
          e.data = m_compress(int'(bus.in_coeff), m_d);
          e.idx  = m_acc;
          e.last = (m_acc == 255);
          q.push_back(e);
          if (int'(bus.in_coeff) >= 3329) m_rerr = 1;
          m_acc++;
        end
        if (start && !m_busy && !m_done) begin
          if (m_legal(int'(d_sel))) begin
            m_busy = 1;
            m_acc  = 0;
            m_d    = int'(d_sel);
            m_rerr = 0;
          end else begin
            new_derr = 1;
          end
        end
      end
      m_done = new_done;
      m_derr = new_derr;
    end
  end

  task automatic clear_stats();
    pop_cnt = 0; last_cnt = 0; first_idx = -1; cyc_last = -100; cyc_done = -200;
    for (int i = 0; i < 256; i++) dut_log[i] = -1;
  endtask

  // Start a polynomial and offer n coefficients, optionally with valid gaps and stray starts.
  task automatic run_poly(input int d, input int n, input bit gaps, input bit rnd_start);
    bit acc;
    int budget;
    @(posedge clk); #1;
    start = 1'b1;
    d_sel = 4'(d);
    @(posedge clk); #1;
    start = 1'b0;
    d_sel = 4'($urandom_range(0, 15));
    for (int i = 0; i < n; i++) begin
      bus.in_coeff = 16'(coeffs[i]);
      bus.in_valid = gaps ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      start = rnd_start ? 1'($urandom_range(0, 7) == 0) : 1'b0;
      acc = 0;
      budget = 0;
      while (!acc) begin
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        @(posedge clk); #1;
        if (!acc) begin
          bus.in_valid = gaps ? 1'($urandom_range(0, 3) != 0) : 1'b1;
          budget++;
          if (budget > 1000) begin
            chk("accept_timeout", 0, 1);
            break;
          end
        end
      end
    end
    bus.in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk("done_seen", int'(seen), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int illegal_d[4] = '{0, 2, 3, 15};
    int t1_in[6]  = '{0, 832, 833, 1665, 3000, 3328};
    int t1_exp[6] = '{0, 0, 1, 1, 0, 0};
    int dc;

    rst = 1'b0; start = 1'b0; abort = 1'b0; d_sel = '0;
    bus.in_valid = 1'b0; bus.in_coeff = '0;
    clear_stats();
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // Pin the model against hand-computed values.
    chk("model_832_d1", m_compress(832, 1), 0);
    chk("model_833_d1", m_compress(833, 1), 1);
    chk("model_3328_d11", m_compress(3328, 11), 2047);
    chk("model_oor", m_compress(3331, 11), 0);

    // 1: d=1 known pattern, always ready.
    for (int i = 0; i < 256; i++) coeffs[i] = (i < 6) ? t1_in[i] : 0;
    rr_mode = 0;
    clear_stats();
    run_poly(1, 256, 0, 0);
    wait_done();
    for (int i = 0; i < 6; i++) begin
      chk("t1_data", dut_log[i], t1_exp[i]);
    end
    chk("t1_done_latency", cyc_done - cyc_last, 1);

    // 2: d=11 top value and out-of-range coefficient.
    for (int i = 0; i < 256; i++) coeffs[i] = $urandom_range(0, 3328);
    coeffs[0] = 3328;
    coeffs[1] = 3331;
    clear_stats();
    run_poly(11, 256, 0, 0);
    wait_done();
    chk("t2_max", dut_log[0], 2047);
    chk("t2_oor_data", dut_log[1], 0);
    chk("t2_range_err", int'(range_err), 1);

    // 3: d=4 with random backpressure, valid gaps and stray starts.
    for (int i = 0; i < 256; i++) coeffs[i] = $urandom_range(0, 3328);
    rr_mode = 1;
    clear_stats();
    run_poly(4, 256, 1, 1);
    wait_done();
    rr_mode = 0;
    chk("t3_pops", pop_cnt, 256);
    chk("t3_lasts", last_cnt, 1);

    // 4: illegal depths raise d_err and leave the block idle.
    foreach (illegal_d[k]) begin
      @(posedge clk); #1;
      start = 1'b1;
      d_sel = 4'(illegal_d[k]);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("t4_d_err", int'(d_err), 1);
      chk("t4_busy", int'(busy), 0);
      chk("t4_in_ready", int'(bus.in_ready), 0);
    end

    // 5: abort after idx 100, then a clean d=10 run.
    for (int i = 0; i < 256; i++) coeffs[i] = $urandom_range(0, 3328);
    dc = done_cnt;
    run_poly(4, 101, 0, 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t5_no_done", done_cnt, dc);
    chk("t5_busy", int'(busy), 0);
    for (int i = 0; i < 256; i++) coeffs[i] = ($urandom_range(0, 15) == 0) ? $urandom_range(3329, 4095) : $urandom_range(0, 3328);
    rr_mode = 1;
    clear_stats();
    run_poly(10, 256, 1, 0);
    wait_done();
    rr_mode = 0;
    chk("t5_first_idx", first_idx, 0);
    chk("t5_pops", pop_cnt, 256);
    chk("t5_done_cnt", done_cnt, dc + 1);

    // 6: async reset while a result is stalled, then recovery with d=5.
    @(posedge clk); #1;
    start = 1'b1;
    d_sel = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      bus.in_coeff = 16'($urandom_range(0, 3328));
      @(posedge clk); #1;
    end
    rr_mode = 2;
    repeat (3) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    #2;
    chk("t6_pre_valid", int'(bus.out_valid), 1);
    rst = 1'b0;
    #1;
    chk("t6_valid", int'(bus.out_valid), 0);
    chk("t6_in_ready", int'(bus.in_ready), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_data", int'(bus.out_data), 0);
    chk("t6_idx", int'(bus.out_idx), 0);
    chk("t6_last", int'(bus.out_last), 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    rr_mode = 0;
    for (int i = 0; i < 256; i++) coeffs[i] = $urandom_range(0, 3328);
    clear_stats();
    run_poly(5, 256, 1, 0);
    wait_done();
    chk("t6_pops", pop_cnt, 256);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
